// File: rtl/memory_bus_responder.sv
// Memory-side responder for the L1 coherence bus: serialises line reads and
// write-backs into word accesses on a single-port synchronous RAM and answers with MEM_RESP.
module memory_bus_responder #(
    parameter int DATA_WIDTH        = 32,
    parameter int ADDRESS_BITS      = 32,
    parameter int CACHE_OFFSET_BITS = 2,
    parameter int MSG_BITS          = 4
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [MSG_BITS-1:0]                             bus_msg_in,
    input  logic [ADDRESS_BITS-1:0]                         bus_address_in,
    input  logic [(1<<CACHE_OFFSET_BITS)*DATA_WIDTH-1:0]    bus_data_in,
    output logic [MSG_BITS-1:0]                             bus_msg_out,
    output logic [ADDRESS_BITS-1:0]                         bus_address_out,
    output logic [(1<<CACHE_OFFSET_BITS)*DATA_WIDTH-1:0]    bus_data_out,
    output logic                                            busy,
    output logic                                            mem_read,
    output logic                                            mem_write,
    output logic [ADDRESS_BITS-1:0]                         mem_address,
    output logic [DATA_WIDTH-1:0]                           mem_data_out,
    input  logic [DATA_WIDTH-1:0]                           mem_data_in
);

    localparam int CACHE_WORDS = 1 << CACHE_OFFSET_BITS;
    localparam int LINE_BITS   = CACHE_WORDS * DATA_WIDTH;
    localparam int CNT_BITS    = CACHE_OFFSET_BITS + 1;

    localparam logic [MSG_BITS-1:0] NO_REQ    = MSG_BITS'(0);
    localparam logic [MSG_BITS-1:0] R_REQ     = MSG_BITS'(1);
    localparam logic [MSG_BITS-1:0] WB_REQ    = MSG_BITS'(2);
    localparam logic [MSG_BITS-1:0] FLUSH     = MSG_BITS'(3);
    localparam logic [MSG_BITS-1:0] RFO_BCAST = MSG_BITS'(6);
    localparam logic [MSG_BITS-1:0] C_WB      = MSG_BITS'(7);
    localparam logic [MSG_BITS-1:0] MEM_RESP  = MSG_BITS'(10);

    localparam logic [CNT_BITS-1:0]     LAST_K      = CNT_BITS'(CACHE_WORDS - 1);
    localparam logic [ADDRESS_BITS-1:0] OFFSET_MASK = ADDRESS_BITS'(CACHE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        RDRAIN = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_BITS-1:0]       k_q, k_d;
    logic [ADDRESS_BITS-1:0]   line_q, line_d;
    logic [LINE_BITS-1:0]      buf_q, buf_d;
    logic                      is_read_q, is_read_d;

    logic                      is_rd_msg, is_wr_msg;
    logic                      cap_en;
    logic [CNT_BITS-1:0]       cap_idx;
    logic [DATA_WIDTH-1:0]     wr_word;

    assign is_rd_msg = (bus_msg_in == R_REQ) || (bus_msg_in == RFO_BCAST);
    assign is_wr_msg = (bus_msg_in == WB_REQ) || (bus_msg_in == FLUSH) || (bus_msg_in == C_WB);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            line_q    <= '0;
            buf_q     <= '0;
            is_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            line_q    <= line_d;
            buf_q     <= buf_d;
            is_read_q <= is_read_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        line_d    = line_q;
        buf_d     = buf_q;
        is_read_d = is_read_q;
        cap_en    = 1'b0;
        cap_idx   = '0;
        case (state_q)
            IDLE: begin
                if (is_rd_msg || is_wr_msg) begin
                    line_d    = bus_address_in & ~OFFSET_MASK;
                    k_d       = '0;
                    is_read_d = is_rd_msg;
                    if (is_wr_msg) begin
                        buf_d = bus_data_in;
                    end
                    state_d = is_rd_msg ? READ : WRITE;
                end
            end
            READ: begin
                // RAM data lags the strobe by one cycle, so beat k lands word k-1.
                if (k_q != '0) begin
                    cap_en  = 1'b1;
                    cap_idx = k_q - CNT_BITS'(1);
                end
                if (k_q == LAST_K) begin
                    state_d = RDRAIN;
                end else begin
                    k_d = k_q + CNT_BITS'(1);
                end
            end
            RDRAIN: begin
                cap_en  = 1'b1;
                cap_idx = k_q;
                state_d = RESP;
            end
            WRITE: begin
                if (k_q == LAST_K) begin
                    state_d = RESP;
                end else begin
                    k_d = k_q + CNT_BITS'(1);
                end
            end
            RESP: begin
                if (bus_msg_in == NO_REQ) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cap_en) begin
            for (int i = 0; i < CACHE_WORDS; i++) begin
                if (cap_idx == CNT_BITS'(i)) begin
                    buf_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_data_in;
                end
            end
        end
    end

    always_comb begin
        wr_word = '0;
        for (int i = 0; i < CACHE_WORDS; i++) begin
            if (k_q == CNT_BITS'(i)) begin
                wr_word = buf_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // All outputs decode from registered state, so reset clears them in the next cycle.
    assign busy            = (state_q != IDLE);
    assign mem_read        = (state_q == READ);
    assign mem_write       = (state_q == WRITE);
    assign mem_address     = (mem_read || mem_write) ? (line_q | ADDRESS_BITS'(k_q)) : '0;
    assign mem_data_out    = mem_write ? wr_word : '0;
    assign bus_msg_out     = (state_q == RESP) ? MEM_RESP : NO_REQ;
    assign bus_address_out = (state_q == RESP) ? line_q : '0;
    assign bus_data_out    = ((state_q == RESP) && is_read_q) ? buf_q : '0;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Directed bench for memory_bus_responder: a behavioural RAM with one-cycle read latency
// plus per-scenario tasks with hand-computed expected cycles and values.
module tb_memory_bus_responder;

    localparam logic [3:0] NO_REQ    = 4'd0;
    localparam logic [3:0] R_REQ     = 4'd1;
    localparam logic [3:0] WB_REQ    = 4'd2;
    localparam logic [3:0] FLUSH     = 4'd3;
    localparam logic [3:0] RFO_BCAST = 4'd6;
    localparam logic [3:0] C_WB      = 4'd7;
    localparam logic [3:0] MEM_RESP  = 4'd10;

    logic         clock;
    logic         reset;
    logic [3:0]   bus_msg_in;
    logic [31:0]  bus_address_in;
    logic [127:0] bus_data_in;
    logic [3:0]   bus_msg_out;
    logic [31:0]  bus_address_out;
    logic [127:0] bus_data_out;
    logic         busy;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [31:0]  mem_data_out;
    logic [31:0]  mem_data_in;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ram [logic [31:0]];
    logic [63:0] wr_log[$];
    logic [63:0] exp_q[$];

    memory_bus_responder dut (
        .clock           (clock),
        .reset           (reset),
        .bus_msg_in      (bus_msg_in),
        .bus_address_in  (bus_address_in),
        .bus_data_in     (bus_data_in),
        .bus_msg_out     (bus_msg_out),
        .bus_address_out (bus_address_out),
        .bus_data_out    (bus_data_out),
        .busy            (busy),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_data_out    (mem_data_out),
        .mem_data_in     (mem_data_in)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // RAM model: writes land at the edge, reads return one cycle after the strobe
    always @(posedge clock) begin
        if (mem_write) begin
            ram[mem_address] = mem_data_out;
            wr_log.push_back({mem_address, mem_data_out});
        end
        if (mem_read) begin
            mem_data_in <= ram.exists(mem_address) ? ram[mem_address] : 32'hDEAD_BEEF;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus_msg_in     = R_REQ;
        bus_address_in = 32'h102;
        bus_data_in    = '0;
        repeat (3) begin
            tick();
            n_checks++;
            if ({bus_msg_out, bus_address_out, bus_data_out, busy, mem_read, mem_write,
                 mem_address, mem_data_out} !== '0)
                $display("FAIL reset_outputs: got msg=%h addr=%h data=%h busy=%b rd=%b wr=%b maddr=%h mdata=%h required all zero",
                         bus_msg_out, bus_address_out, bus_data_out, busy, mem_read, mem_write,
                         mem_address, mem_data_out);
            else
                n_pass++;
        end
        reset = 1'b0;
    endtask

    task automatic test_read(input logic [31:0] addr, input logic [127:0] exp_line,
                             input bit short_hs, input logic [3:0] msg, input string name);
        logic [31:0] line;
        line           = addr & ~32'h3;
        bus_msg_in     = msg;
        bus_address_in = addr;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({busy, mem_read, mem_write, mem_address, bus_msg_out} !==
                {1'b1, 1'b1, 1'b0, line + 32'(i), NO_REQ})
                $display("FAIL %s_beat%0d: got busy=%b rd=%b wr=%b addr=%h msg=%h required busy=1 rd=1 wr=0 addr=%h msg=0",
                         name, i, busy, mem_read, mem_write, mem_address, bus_msg_out, line + 32'(i));
            else
                n_pass++;
            tick();
        end
        n_checks++;
        if ({busy, mem_read, mem_write, bus_msg_out} !== {1'b1, 1'b0, 1'b0, NO_REQ})
            $display("FAIL %s_drain: got busy=%b rd=%b wr=%b msg=%h required busy=1 rd=0 wr=0 msg=0",
                     name, busy, mem_read, mem_write, bus_msg_out);
        else
            n_pass++;
        tick();
        n_checks++;
        if ({bus_msg_out, bus_address_out, bus_data_out, busy} !== {MEM_RESP, line, exp_line, 1'b1})
            $display("FAIL %s_resp: got msg=%h addr=%h data=%h busy=%b required msg=a addr=%h data=%h busy=1",
                     name, bus_msg_out, bus_address_out, bus_data_out, busy, line, exp_line);
        else
            n_pass++;
        if (!short_hs) begin
            repeat (2) begin
                tick();
                n_checks++;
                if ({bus_msg_out, bus_address_out, bus_data_out} !== {MEM_RESP, line, exp_line})
                    $display("FAIL %s_hold: got msg=%h addr=%h data=%h required msg=a addr=%h data=%h",
                             name, bus_msg_out, bus_address_out, bus_data_out, line, exp_line);
                else
                    n_pass++;
            end
        end
        bus_msg_in = NO_REQ;
        tick();
        n_checks++;
        if ({bus_msg_out, bus_address_out, bus_data_out, busy} !== '0)
            $display("FAIL %s_release: got msg=%h addr=%h data=%h busy=%b required all zero",
                     name, bus_msg_out, bus_address_out, bus_data_out, busy);
        else
            n_pass++;
    endtask

    task automatic test_write(input logic [31:0] addr, input logic [127:0] wline,
                              input logic [3:0] msg, input string name);
        logic [31:0] line;
        line = addr & ~32'h3;
        wr_log.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({line + 32'(i), wline[i*32 +: 32]});
        bus_msg_in     = msg;
        bus_address_in = addr;
        bus_data_in    = wline;
        tick();
        bus_data_in = '0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({busy, mem_read, mem_write, mem_address, mem_data_out} !==
                {1'b1, 1'b0, 1'b1, exp_q[i]})
                $display("FAIL %s_beat%0d: got busy=%b rd=%b wr=%b addr=%h data=%h required busy=1 rd=0 wr=1 addr/data=%h",
                         name, i, busy, mem_read, mem_write, mem_address, mem_data_out, exp_q[i]);
            else
                n_pass++;
            tick();
        end
        n_checks++;
        if ({bus_msg_out, bus_address_out, bus_data_out, mem_write} !== {MEM_RESP, line, 128'd0, 1'b0})
            $display("FAIL %s_resp: got msg=%h addr=%h data=%h wr=%b required msg=a addr=%h data=0 wr=0",
                     name, bus_msg_out, bus_address_out, bus_data_out, mem_write, line);
        else
            n_pass++;
        bus_msg_in = NO_REQ;
        tick();
        n_checks++;
        if ({bus_msg_out, busy} !== '0)
            $display("FAIL %s_release: got msg=%h busy=%b required 0/0", name, bus_msg_out, busy);
        else
            n_pass++;
        n_checks++;
        if (wr_log !== exp_q)
            $display("FAIL %s_ram_log: got %0d writes required %0d matching writes", name,
                     wr_log.size(), exp_q.size());
        else
            n_pass++;
    endtask

    task automatic test_ignored();
        logic [3:0] ign [4];
        ign = '{4'd5, 4'd14, 4'd11, 4'd15};
        for (int m = 0; m < 4; m++) begin
            bus_msg_in     = ign[m];
            bus_address_in = 32'h500;
            repeat (3) begin
                tick();
                n_checks++;
                if ({busy, mem_read, mem_write, bus_msg_out} !== '0)
                    $display("FAIL ignored_msg%0d: got busy=%b rd=%b wr=%b msg=%h required all zero",
                             ign[m], busy, mem_read, mem_write, bus_msg_out);
                else
                    n_pass++;
            end
        end
        bus_msg_in = NO_REQ;
        tick();
    endtask

    task automatic test_midop_reset();
        wr_log.delete();
        exp_q.delete();
        exp_q.push_back({32'h300, 32'h10});
        exp_q.push_back({32'h301, 32'h11});
        bus_msg_in     = WB_REQ;
        bus_address_in = 32'h300;
        bus_data_in    = {32'h13, 32'h12, 32'h11, 32'h10};
        tick();
        tick();
        n_checks++;
        if ({mem_write, mem_address, mem_data_out} !== {1'b1, 32'h301, 32'h11})
            $display("FAIL midop_second_beat: got wr=%b addr=%h data=%h required wr=1 addr=301 data=11",
                     mem_write, mem_address, mem_data_out);
        else
            n_pass++;
        reset       = 1'b1;
        bus_msg_in  = NO_REQ;
        bus_data_in = '0;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({bus_msg_out, bus_address_out, bus_data_out, busy, mem_read, mem_write,
             mem_address, mem_data_out} !== '0)
            $display("FAIL midop_reset_outputs: got msg=%h busy=%b rd=%b wr=%b maddr=%h mdata=%h required all zero",
                     bus_msg_out, busy, mem_read, mem_write, mem_address, mem_data_out);
        else
            n_pass++;
        repeat (3) tick();
        n_checks++;
        if (wr_log !== exp_q)
            $display("FAIL midop_ram_log: got %0d writes required 2 writes (300,301)", wr_log.size());
        else
            n_pass++;
        n_checks++;
        if ((ram.exists(32'h302) || ram.exists(32'h303)) !== 1'b0)
            $display("FAIL midop_unwritten: got 302/303 present=%b required 0",
                     ram.exists(32'h302) || ram.exists(32'h303));
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        test_read(32'h101, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1, R_REQ, "short_hs");
        test_read(32'h206, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, RFO_BCAST, "b2b_rfo");
    endtask

    initial begin
        reset          = 1'b1;
        bus_msg_in     = NO_REQ;
        bus_address_in = '0;
        bus_data_in    = '0;
        ram[32'h100] = 32'hA0;
        ram[32'h101] = 32'hA1;
        ram[32'h102] = 32'hA2;
        ram[32'h103] = 32'hA3;

        test_reset();
        test_read(32'h102, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0, R_REQ, "read_line");
        test_write(32'h204, {32'd4, 32'd3, 32'd2, 32'd1}, WB_REQ, "wb");
        test_read(32'h204, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, R_REQ, "wb_readback");
        test_write(32'h40B, {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000},
                   C_WB, "cwb");
        test_write(32'h600, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, FLUSH, "flush");
        test_read(32'h409, {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000},
                  1'b0, R_REQ, "cwb_readback");
        test_ignored();
        test_midop_reset();
        test_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
